m_fmap_relay: RTL and testbench
===============================

# m_fmap_relay

Inter-layer feature-map relay: captures a convolution stage's `save`-qualified `map_out` results into an internal single-port-per-direction buffer. Once the full map is held, it replays the map as a continuous `map_in`/`start` stream for the next convolution stage, then appends zero flush samples. It sits between two `m_conv_*` instances, acting as the sink of one and the source of the next.

## Interface
Parameters:
- `DATA_W`, 16, sample width (signed Q-format, passed through unchanged)
- `DEPTH`, 7744, samples per feature map
- `ADDR_W`, 13, address width, ≥ clog2(DEPTH)
- `TAIL`, 864, zero samples appended after the map to flush the consumer's line shift register

Ports:
- `clk_in`  in  1  clock
- `rst_n`  in  1  reset; asynchronous and active-high (asserted = 1) despite the name
- `map_in`  in  DATA_W  upstream result sample
- `save`  in  1  upstream sample-valid strobe
- `nxt_ready`  in  1  downstream stage idle and able to accept a new map
- `map_out`  out  DATA_W  replayed sample to the downstream stage
- `start`  out  1  downstream enable; high for the whole replay including tail
- `full`  out  1  buffer holds a complete map that has not yet been replayed
- `ovf`  out  1  sticky flag: `save` arrived while the block was not in FILL

## Operation
States:
- FILL
  - When `save`=1: write `map_in` at `wr_addr`, then increment `wr_addr`.
  - If a write occurs with `wr_addr`==DEPTH-1: go to HOLD, with `wr_addr` set to 0.
- HOLD
  - `full`=1; waits for `nxt_ready`.
  - When `nxt_ready`=1: go to READ, with `rd_addr`=0.
- READ
  - Issue `rd_addr` every cycle.
  - After issuing DEPTH-1, go to FLUSH with `tail_cnt`=0.
- FLUSH
  - Drives 0 on `map_out`; counts TAIL cycles.
  - When the count ends: go to FILL.

Rules:
- `save` outside FILL: sample discarded and `ovf` set. `ovf` clears only on reset.
- `full` drops in the first READ cycle.
- Samples are stored and replayed bit-exact, with no arithmetic applied. Replay order equals write order.
- `nxt_ready` is ignored outside HOLD.
- TAIL=0 is legal: READ goes directly to FILL.
- Asynchronous reset mid-operation:
  - Outputs go to reset values and state goes to FILL.
  - Both addresses and `tail_cnt` are cleared.
  - Buffer contents are not cleared, and they are not valid afterwards.

## Timing
Reset values: `map_out`=0, `start`=0, `full`=0, `ovf`=0.

Write path:
- A write commits on the clock edge where `save`=1 is sampled.
- HOLD is entered on the edge after the DEPTH-th write, so `full`=1 is visible one cycle after that write.

Read path:
- Buffer read is registered with 1-cycle latency. `rd_addr` issued at cycle t appears on `map_out` at t+1.
- `start` rises together with sample 0 on `map_out`, one cycle after the HOLD→READ edge.
- `start` stays high for exactly DEPTH+TAIL consecutive cycles and falls the cycle after the last tail zero.
- `map_out` carries 0 whenever `start`=0.

Throughput and back-to-back:
- A `save` in the FILL entry cycle (the cycle after `start` falls) is accepted.
- Minimum period per map is DEPTH (fill) + 1 (HOLD) + DEPTH + TAIL + 1 cycles.
- There is no overlap between fill and replay; this is a single-buffer design.

## Structure
- Shared package (`cnn_pkg`): `DATA_W`, and a per-layer `DEPTH`/`TAIL` constant set (e.g. `L1_OUT=7744`, `L2_SHIFT=864`) reused by the conv and relay instances. The state encoding (FILL/HOLD/READ/FLUSH) stays local.
- One sub-module, `m_fmap_ram`: simple dual-port RAM, DEPTH×DATA_W.
  - One write port (`we`, `wa`, `wd`) and one read port (`ra`, registered `rd`).
  - Inferable as block RAM.
  - The control FSM and counters live in `m_fmap_relay`.

## Test plan
All scenarios use DEPTH=8, TAIL=3.
- **Reset defaults:** assert `rst_n`=1 mid-cycle, then release → all outputs 0 asynchronously; after release the state is FILL and `full`=0.
- **Basic fill and replay:** `save` for 8 consecutive cycles with `map_in`=1..8, `nxt_ready`=1 → `full` high for 1 cycle. `start` is high for 11 cycles; `map_out`=1,2,…,8,0,0,0; `start` then falls.
- **Gapped fill and HOLD:** `save` on alternate cycles with values −1,−2,…,−8 (0xFFFF…) and `nxt_ready`=0 → `full` stays 1 and `start`=0 indefinitely. Raising `nxt_ready` gives replay of 0xFFFF…0xFFF8 in order, with sign bits preserved.
- **Overflow:** pulse `save` during HOLD and during READ → `ovf`=1 and stays 1. The replayed data is unchanged, and the next fill starts at address 0.
- **Reset mid-replay:** assert reset at the 4th `start` cycle → `start`=0 immediately. A new 8-sample fill of 9..16 replays as 9..16.
- **Back-to-back maps:** two maps (1..8, then 11..18), with the second fill beginning in the first FILL cycle after `start` falls → both replays are correct, and `ovf`=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN datapath width and per-layer map/flush sizes
package cnn_pkg;
  localparam int DATA_W = 16;
  localparam int L1_OUT = 7744;
  localparam int L2_SHIFT = 864;
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/m_fmap_ram.sv
// m_fmap_ram: simple dual-port feature-map RAM with registered read
module m_fmap_ram import cnn_pkg::*; #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int DEPTH = L1_OUT,
  parameter int ADDR_W = addr_w(L1_OUT)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem [DEPTH];
  // write port and registered read port, no reset so it maps to block RAM
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/m_fmap_relay.sv
// m_fmap_relay: buffers one full feature map, then replays it plus a zero flush tail
module m_fmap_relay import cnn_pkg::*; #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int DEPTH = L1_OUT,
  parameter int ADDR_W = addr_w(L1_OUT),
  parameter int TAIL = L2_SHIFT
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] map_in,
  input  logic              save,
  input  logic              nxt_ready,
  output logic [DATA_W-1:0] map_out,
  output logic              start,
  output logic              full,
  output logic              ovf
);
  typedef enum logic [1:0] {FILL, HOLD, READ, FLUSH} state_t;
  localparam int TW = $clog2(TAIL + 2);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [TW-1:0] TEND = TW'(TAIL);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [TW-1:0] tail_cnt;
  logic rd_vld, we;
  logic [DATA_W-1:0] rd;
  m_fmap_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk_in), .we(we), .wa(wr_addr), .wd(map_in), .ra(rd_addr), .rd(rd)
  );
  // next state and outputs; FLUSH runs TAIL zero cycles plus one idle turnaround
  always_comb begin
    we = state == FILL && save;
    state_nxt = (we && wr_addr == LAST) ? HOLD :
                (state == HOLD && nxt_ready) ? READ :
                (state == READ && rd_addr == LAST) ? (TAIL == 0 ? FILL : FLUSH) :
                (state == FLUSH && tail_cnt == TEND) ? FILL : state;
    full = state == HOLD;
    map_out = rd_vld ? rd : '0;
  end
  // state, address counters and output registers aligned to the RAM read latency
  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      state <= FILL;
      wr_addr <= '0;
      rd_addr <= '0;
      tail_cnt <= '0;
      rd_vld <= 1'b0;
      start <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (we) wr_addr <= wr_addr == LAST ? '0 : wr_addr + 1'b1;
      rd_addr <= (state == READ && rd_addr != LAST) ? rd_addr + 1'b1 : '0;
      tail_cnt <= state == FLUSH ? tail_cnt + 1'b1 : '0;
      rd_vld <= state == READ;
      start <= state == READ || (state == FLUSH && tail_cnt != TEND);
      ovf <= ovf | (save && state != FILL);
    end
  end
endmodule

// File: tb/tb_m_fmap_relay.sv
// tb_m_fmap_relay: directed and random checks of the relay against a stream-level model
module tb_m_fmap_relay;
  localparam int DEPTH = 8;
  localparam int TAIL = 3;
  logic clk_in = 1'b0, rst_n = 1'b1, save = 1'b0, nxt_ready = 1'b0;
  logic [15:0] map_in = '0;
  logic [15:0] map_out;
  logic start, full, ovf;
  int checks = 0, errors = 0, full_cnt;
  logic [15:0] got[$];
  logic [15:0] m_buf[$];
  int m_exp[$];
  int m_busy;
  bit m_full, m_ovf;

  always #5 clk_in = ~clk_in;

  m_fmap_relay #(.DATA_W(16), .DEPTH(DEPTH), .ADDR_W(3), .TAIL(TAIL)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .map_in(map_in), .save(save), .nxt_ready(nxt_ready),
    .map_out(map_out), .start(start), .full(full), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // model: collect a map; when full and released, expect one idle cycle, the map, then TAIL zeros
  always @(posedge clk_in or posedge rst_n) begin
    bit acc;
    if (rst_n) begin
      m_buf.delete();
      m_exp.delete();
      m_busy = 0;
      m_full = 0;
      m_ovf = 0;
    end else begin
      acc = !m_full && m_busy == 0;
      if (m_busy > 0) m_busy--;
      if (m_full && nxt_ready) begin
        m_full = 0;
        m_exp.push_back(-1);
        foreach (m_buf[i]) m_exp.push_back(int'(m_buf[i]));
        repeat (TAIL) m_exp.push_back(0);
        m_buf.delete();
        m_busy = DEPTH + TAIL + 1;
      end else if (save && acc) begin
        m_buf.push_back(map_in);
        if (m_buf.size() == DEPTH) m_full = 1;
      end
      if (save && !acc) m_ovf = 1;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk_in) begin
    int e;
    if (!rst_n) begin
      e = m_exp.size() > 0 ? m_exp.pop_front() : -1;
      chk("start", start, e >= 0);
      chk("map_out", map_out, e >= 0 ? 16'(e) : 16'h0);
      chk("full", full, m_full);
      chk("ovf", ovf, m_ovf);
    end
  end

  task automatic fill_seq(input int first, input int step, input bit gap);
    for (int i = 0; i < DEPTH; i++) begin
      save = 1'b1;
      map_in = 16'(first + step * i);
      @(negedge clk_in);
      save = 1'b0;
      if (gap) @(negedge clk_in);
    end
  endtask

  task automatic capture();
    int n = 0;
    got.delete();
    full_cnt = 0;
    while (!start && n < 100) begin
      full_cnt += full;
      @(negedge clk_in);
      n++;
    end
    while (start && n < 100) begin
      full_cnt += full;
      got.push_back(map_out);
      @(negedge clk_in);
      n++;
    end
    if (n >= 100) chk("capture_timeout", n, 0);
  endtask

  task automatic chk_stream(input int first, input int step);
    chk("stream_len", got.size(), DEPTH + TAIL);
    for (int i = 0; i < got.size() && i < DEPTH + TAIL; i++)
      chk($sformatf("stream[%0d]", i), got[i], i < DEPTH ? 16'(first + step * i) : 16'h0);
  endtask

  initial begin
    int n, cnt;
    repeat (2) @(negedge clk_in);
    chk("rst_map_out", map_out, 0);
    chk("rst_start", start, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      save = 1'b1;
      map_in = 16'(100 + i);
      @(negedge clk_in);
    end
    save = 1'b0;
    #2 rst_n = 1'b1;
    #1 chk("async_rst_start", start, 0);
    chk("async_rst_full", full, 0);
    @(negedge clk_in);
    rst_n = 1'b0;
    nxt_ready = 1'b1;
    fill_seq(1, 1, 0);
    capture();
    chk("basic_full_cycles", full_cnt, 1);
    chk_stream(1, 1);
    nxt_ready = 1'b0;
    fill_seq(-1, -1, 1);
    repeat (20) @(negedge clk_in);
    chk("hold_full", full, 1);
    chk("hold_start", start, 0);
    nxt_ready = 1'b1;
    capture();
    chk_stream(-1, -1);
    chk("gap_first", got.size() > 0 ? got[0] : 16'h0, 16'hFFFF);
    nxt_ready = 1'b0;
    fill_seq(50, 3, 0);
    save = 1'b1;
    map_in = 16'h1234;
    @(negedge clk_in);
    save = 1'b0;
    chk("ovf_hold", ovf, 1);
    nxt_ready = 1'b1;
    @(negedge clk_in);
    nxt_ready = 1'b0;
    save = 1'b1;
    map_in = 16'hBEEF;
    @(negedge clk_in);
    save = 1'b0;
    capture();
    chk_stream(50, 3);
    fill_seq(200, 1, 0);
    nxt_ready = 1'b1;
    capture();
    chk_stream(200, 1);
    chk("ovf_sticky", ovf, 1);
    fill_seq(300, 7, 0);
    n = 0;
    cnt = 0;
    while (cnt < 4 && n < 100) begin
      @(negedge clk_in);
      n++;
      if (start) cnt++;
    end
    chk("start4_found", cnt, 4);
    #1 rst_n = 1'b1;
    #1 chk("mid_rst_start", start, 0);
    chk("mid_rst_map_out", map_out, 0);
    chk("mid_rst_ovf", ovf, 0);
    @(negedge clk_in);
    rst_n = 1'b0;
    fill_seq(9, 1, 0);
    capture();
    chk_stream(9, 1);
    fill_seq(1, 1, 0);
    capture();
    chk_stream(1, 1);
    fill_seq(11, 1, 0);
    capture();
    chk_stream(11, 1);
    chk("b2b_ovf", ovf, 0);
    repeat (400) begin
      save = $urandom_range(0, 3) != 0;
      map_in = 16'($urandom);
      nxt_ready = $urandom_range(0, 2) == 0;
      @(negedge clk_in);
    end
    save = 1'b0;
    nxt_ready = 1'b0;
    repeat (2) @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
